spi_transaction_sequencer: RTL and testbench

Upstream command generator for the SPI control interface. On a start request it loads N transmit bytes into the interface's data memory, writes the control register to launch the burst, polls until the interface clears the send bit, then reads back the received bytes. The last received byte is held for the 7-segment display path. Busy, done and timeout status are exported.

---
 rtl/spi_transaction_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_spi_transaction_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_sequencer.sv
// SPI burst sequencer: fills the SPI data memory, launches the burst,
// polls the send bit, then reads the received bytes back.
module spi_transaction_sequencer #(
  parameter int         N_WORDS      = 4,
  parameter logic [7:0] BASE_BYTE    = 8'hA0,
  parameter int         POLL_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio_i,
  input  logic [31:0] salida_i,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic [31:0] addr_o,
  output logic [31:0] entrada_o,
  output logic [7:0]  dato_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int TW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [8:0] K_LAST = 9'(N_WORDS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_TIMEOUT - 1);
  localparam logic [31:0] CTRL_W = (32'(N_WORDS - 1) << 4) | 32'h1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_CTRL,
    S_POLL_REQ,
    S_POLL_CHK,
    S_RD_REQ,
    S_RD_CAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [8:0]    r_k;
  logic [8:0]    w_k_n;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_n;
  logic          r_ini_d;

  logic        r_wr;
  logic        r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_ent;
  logic [7:0]  r_dato;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_wr_n;
  logic        w_sel_n;
  logic [31:0] w_addr_n;
  logic [31:0] w_ent_n;
  logic [7:0]  w_dato_n;
  logic        w_busy_n;
  logic        w_done_n;
  logic        w_err_n;

  logic w_start;
  logic w_tmo_hit;
  logic w_unused;

  assign w_start   = inicio_i & ~r_ini_d;
  assign w_tmo_hit = (r_tmo == T_LAST);
  assign w_unused  = ^salida_i[31:8];

  assign wr_o      = r_wr;
  assign reg_sel_o = r_sel;
  assign addr_o    = r_addr;
  assign entrada_o = r_ent;
  assign dato_o    = r_dato;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign error_o   = r_err;

  // State, counters, start edge detector and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_tmo   <= '0;
      r_ini_d <= 1'b0;
      r_wr    <= 1'b0;
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_ent   <= '0;
      r_dato  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      r_tmo   <= w_tmo_n;
      r_ini_d <= inicio_i;
      r_wr    <= w_wr_n;
      r_sel   <= w_sel_n;
      r_addr  <= w_addr_n;
      r_ent   <= w_ent_n;
      r_dato  <= w_dato_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end

  // Next state, word/timeout counters, captured byte and error flag
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_tmo_n   = r_tmo;
    w_dato_n  = r_dato;
    w_err_n   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_n = S_WR_DATA;
          w_k_n     = '0;
          w_err_n   = 1'b0;
        end
      end
      S_WR_DATA: begin
        if (r_k == K_LAST) begin
          w_state_n = S_WR_CTRL;
        end else begin
          w_k_n = r_k + 9'd1;
        end
      end
      S_WR_CTRL: begin
        w_state_n = S_POLL_REQ;
        w_tmo_n   = '0;
      end
      S_POLL_REQ: begin
        w_tmo_n   = r_tmo + 1'b1;
        w_state_n = w_tmo_hit ? S_ERR : S_POLL_CHK;
      end
      S_POLL_CHK: begin
        w_tmo_n = r_tmo + 1'b1;
        if (w_tmo_hit) begin
          w_state_n = S_ERR;
        end else if (!salida_i[0]) begin
          w_state_n = S_RD_REQ;
          w_k_n     = '0;
        end else begin
          w_state_n = S_POLL_REQ;
        end
      end
      S_RD_REQ: begin
        w_state_n = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_dato_n = salida_i[7:0];
        if (r_k == K_LAST) begin
          w_state_n = S_DONE;
        end else begin
          w_k_n     = r_k + 9'd1;
          w_state_n = S_RD_REQ;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      S_ERR: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    if (w_state_n == S_ERR) begin
      w_err_n = 1'b1;
    end
  end

  // Bus outputs for the state being entered, so they register with it
  always_comb begin
    w_wr_n   = 1'b0;
    w_sel_n  = 1'b0;
    w_addr_n = '0;
    w_ent_n  = '0;
    w_busy_n = 1'b1;
    w_done_n = 1'b0;
    unique case (w_state_n)
      S_WR_DATA: begin
        w_wr_n   = 1'b1;
        w_sel_n  = 1'b1;
        w_addr_n = {23'b0, w_k_n};
        w_ent_n  = {24'b0, BASE_BYTE + w_k_n[7:0]};
      end
      S_WR_CTRL: begin
        w_wr_n  = 1'b1;
        w_ent_n = CTRL_W;
      end
      S_RD_REQ, S_RD_CAP: begin
        w_sel_n  = 1'b1;
        w_addr_n = {23'b0, w_k_n};
      end
      S_DONE: begin
        w_busy_n = 1'b0;
        w_done_n = 1'b1;
      end
      S_IDLE, S_ERR: begin
        w_busy_n = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Bench for spi_transaction_sequencer: SPI interface model, write
// scoreboard, vector table plus reset and N_WORDS=1 sequences.
module tb_spi_transaction_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inicio = 1'b0;
  logic [31:0] salida = '0;
  logic        wr, sel, busy, done, err;
  logic [31:0] addr, ent;
  logic [7:0]  dato;

  logic        inicio1 = 1'b0;
  logic [31:0] salida1 = '0;
  logic        wr1, sel1, busy1, done1, err1;
  logic [31:0] addr1, ent1;
  logic [7:0]  dato1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  spi_transaction_sequencer #(
    .N_WORDS(4), .BASE_BYTE(8'hA0), .POLL_TIMEOUT(50)
  ) u0 (
    .clk(clk), .rst(rst), .inicio_i(inicio), .salida_i(salida),
    .wr_o(wr), .reg_sel_o(sel), .addr_o(addr), .entrada_o(ent),
    .dato_o(dato), .busy_o(busy), .done_o(done), .error_o(err)
  );

  spi_transaction_sequencer #(
    .N_WORDS(1), .BASE_BYTE(8'h7E), .POLL_TIMEOUT(50)
  ) u1 (
    .clk(clk), .rst(rst), .inicio_i(inicio1), .salida_i(salida1),
    .wr_o(wr1), .reg_sel_o(sel1), .addr_o(addr1), .entrada_o(ent1),
    .dato_o(dato1), .busy_o(busy1), .done_o(done1), .error_o(err1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI interface model: send bit clears dly cycles after launch
  logic        send = 1'b0;
  int          scnt = 0;
  int          dly = 40;
  logic [31:0] rxw = '0;
  always @(posedge clk) begin
    if (wr && !sel) begin
      send <= ent[0];
      scnt <= 0;
    end else if (send && dly >= 0) begin
      scnt <= scnt + 1;
      if (scnt >= dly) send <= 1'b0;
    end
    salida <= sel ? {24'h0, rxw[{addr[1:0], 3'b000} +: 8]}
                  : {31'h0, send};
  end

  // N_WORDS=1 model: send already clear, junk in unused bits
  always @(posedge clk)
    salida1 <= sel1 ? 32'hFFFF_FFC3 : 32'hFFFF_FFFE;

  typedef struct {
    logic        rs;
    logic [31:0] a;
    logic [31:0] d;
    int          off;
  } wr_t;

  wr_t sbq[$];
  int  t_start = 0;
  int  t_ctrl = 0;
  int  n_done = 0;

  always @(negedge clk) begin : mon
    wr_t e;
    if (done) n_done = n_done + 1;
    if (wr) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_write: sel=%0d addr=%0h data=%0h expected none",
                 sel, addr, ent);
      end else begin
        e = sbq.pop_front();
        chk("wr_sel_addr", {31'h0, sel, addr}, {31'h0, e.rs, e.a});
        chk("wr_data", {32'h0, ent}, {32'h0, e.d});
        chk("wr_cycle", 64'(cyc - t_start), 64'(e.off));
        if (!sel) t_ctrl = cyc;
      end
    end
  end

  int          n1 = 0;
  int          nd1 = 0;
  logic        s1[4];
  logic [31:0] a1[4];
  logic [31:0] d1[4];
  int          c1[4];
  always @(negedge clk) begin
    if (done1) nd1 = nd1 + 1;
    if (wr1) begin
      if (n1 < 4) begin
        s1[n1] = sel1;
        a1[n1] = addr1;
        d1[n1] = ent1;
        c1[n1] = cyc;
      end
      n1 = n1 + 1;
    end
  end

  task automatic push_burst();
    for (int k = 0; k < 4; k++)
      sbq.push_back(wr_t'{1'b1, 32'(k), {24'h0, 8'(8'hA0 + k)}, 1 + k});
    sbq.push_back(wr_t'{1'b0, 32'h0, 32'h31, 5});
  endtask

  typedef struct {
    int          dly;
    logic [31:0] b;
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_dato;
    int          hold;
    int          rep;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    int   nd0;
    int   ecyc;
    logic got;
    dly = v.dly;
    rxw = v.b;
    @(negedge clk);
    nd0 = n_done;
    got = 1'b0;
    ecyc = -1;
    inicio = 1'b1;
    t_start = cyc;
    push_burst();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("busy_on", 64'(busy), 64'd1);
        chk("err_cleared", 64'(err), 64'd0);
      end
      inicio = ((c + 1) < v.hold) || (v.rep != 0 && c == v.rep);
      if (err && ecyc < 0) ecyc = cyc;
      if (done || err) got = 1'b1;
      if (got && (c + 1) >= v.hold && c > v.rep + 1) break;
    end
    inicio = 1'b0;
    chk("finished", 64'(got), 64'd1);
    repeat (4) @(negedge clk);
    chk("done_pulses", 64'(n_done - nd0), 64'(v.exp_done));
    chk("error", 64'(err), 64'(v.exp_err));
    chk("dato", 64'(dato), 64'(v.exp_dato));
    chk("busy_off", 64'(busy), 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    if (v.exp_err) chk("timeout_latency", 64'(ecyc - t_ctrl), 64'd51);
    sbq.delete();
  endtask

  initial begin
    logic found;
    int   ts1;
    logic got1;

    vt[0] = '{40, 32'h44332211, 1'b1, 1'b0, 8'h44, 1, 0};
    vt[1] = '{1, 32'hFF030201, 1'b1, 1'b0, 8'hFF, 1, 0};
    vt[2] = '{-1, 32'hDDCCBBAA, 1'b0, 1'b1, 8'hFF, 1, 0};
    vt[3] = '{10, 32'h8D7C6B5A, 1'b1, 1'b0, 8'h8D, 500, 0};
    vt[4] = '{40, 32'h40302010, 1'b1, 1'b0, 8'h40, 1, 15};
    vt[5] = '{5, 32'h67452301, 1'b1, 1'b0, 8'h67, 1, 0};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_ctl", {56'h0, wr, sel, busy, done, err, dato[2:0]} |
                     {56'h0, dato}, 64'd0);
    chk("reset_bus", {addr, ent}, 64'd0);
    repeat (50) @(negedge clk);
    chk("idle_ctl", {55'h0, wr, dato, busy, done, err} |
                    {63'h0, sel}, 64'd0);
    chk("idle_bus", {addr, ent}, 64'd0);
    chk("idle_u1", {32'h0, addr1 | ent1} |
                   {59'h0, wr1, sel1, busy1, done1, err1}, 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    dly = 40;
    @(negedge clk);
    inicio = 1'b1;
    t_start = cyc;
    push_burst();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      inicio = 1'b0;
      if (wr && sel && addr == 32'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_k2", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_ctl", {55'h0, wr, sel, busy, done, err, dato[3:0]} |
                     {56'h0, dato}, 64'd0);
    chk("abort_bus", {addr, ent}, 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    run_vec(vt[5]);

    @(negedge clk);
    inicio1 = 1'b1;
    ts1 = cyc;
    got1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      inicio1 = 1'b0;
      if (done1) begin
        got1 = 1'b1;
        break;
      end
    end
    chk("n1_finished", 64'(got1), 64'd1);
    repeat (3) @(negedge clk);
    chk("n1_writes", 64'(n1), 64'd2);
    if (n1 >= 2) begin
      chk("n1_data_wr", {31'h0, s1[0], a1[0]}, {31'h0, 1'b1, 32'h0});
      chk("n1_data_val", 64'(d1[0]), 64'h7E);
      chk("n1_data_cyc", 64'(c1[0] - ts1), 64'd1);
      chk("n1_ctrl_sel", 64'(s1[1]), 64'd0);
      chk("n1_ctrl_val", 64'(d1[1]), 64'h1);
      chk("n1_ctrl_cyc", 64'(c1[1] - ts1), 64'd2);
    end
    chk("n1_done", 64'(nd1), 64'd1);
    chk("n1_dato", 64'(dato1), 64'hC3);
    chk("n1_status", {61'h0, busy1, err1, done1}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
